regfile_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 8 x 16-bit register file among NREQ requesters (ALU writeback, load unit, debug/host port, ...). Each requester presents a valid/ready write request. The block selects one winner per cycle and drives the register file's wr_en/wr_addr/wr_data from registered outputs. A per-requester lock lets one requester own the port for back-to-back writes without interleaving from the others.

---
 rtl/regfile_wr_arbiter_if.sv | 29 ++
 rtl/regfile_wr_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side write bus and register-file write port of the regfile write arbiter.
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 16
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [OW-1:0]      owner;
    logic               locked;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, owner, locked
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, owner, locked
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter with per-requester lock for the single register-file write port.
module regfile_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wr_arbiter_if.slave   bus
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic {S_ARB = 1'b0, S_LOCKED = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [OW-1:0]   win;
    logic            win_vld;
    logic            xfer;
    logic [NREQ-1:0] ready;
    int              j;

    // Winner: owner while locked, otherwise first valid scanning up from ptr with wrap
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        j       = 0;
        if (state_q == S_LOCKED) begin
            win     = owner_q;
            win_vld = bus.req_valid[owner_q];
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                j = int'(ptr_q) + k;
                if (j >= NREQ) j = j - NREQ;
                if (!win_vld && bus.req_valid[j]) begin
                    win_vld = 1'b1;
                    win     = OW'(j);
                end
            end
        end
    end

    assign xfer = win_vld && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        wr_en_d   = xfer;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            wr_addr_d = bus.req_addr[win*AW +: AW];
            wr_data_d = bus.req_data[win*DW +: DW];
            case (state_q)
                S_ARB: begin
                    ptr_d = (win == OW'(NREQ-1)) ? '0 : win + OW'(1);
                    if (bus.req_lock[win]) begin
                        state_d = S_LOCKED;
                        owner_d = win;
                    end
                end
                S_LOCKED: begin
                    // Unlocking transfer still writes; release takes effect next cycle
                    if (!bus.req_lock[win]) state_d = S_ARB;
                end
                default: state_d = S_ARB;
            endcase
        end
    end

    always_comb begin
        ready = '0;
        if (xfer) ready[win] = 1'b1;
    end

    assign bus.req_ready = ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.owner     = owner_q;
    assign bus.locked    = (state_q == S_LOCKED);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: queue/arithmetic reference model plus literal checks.
module tb_regfile_wr_arbiter;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();
    regfile_wr_arbiter_if #(.NREQ(2), .AW(AW), .DW(DW)) bus2 ();

    regfile_wr_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut  (.clk(clk), .rst(rst), .bus(bus));
    regfile_wr_arbiter #(.NREQ(2), .AW(AW), .DW(DW)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // reference model state
    int          m_ptr = 0, m_owner = 0, m2_next = 0;
    bit          m_locked = 1'b0, m_wr_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int gq[$];
    int g2q[$];

    int exp2[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp3[7] = '{0, 1, 1, 1, 1, 1, 3};
    int exp4[3] = '{0, 0, 2};
    int exp6[4] = '{0, 1, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    function automatic int model_grant();
        if (rst) return -1;
        if (m_locked) return bus.req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++)
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // compare process
    always @(negedge clk) begin
        int g;
        logic [N-1:0] er;
        if (chk_en) begin
            g  = model_grant();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("ready", 32'(bus.req_ready), 32'(er));
            chk("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
            chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
            chk("wr_data", 32'(bus.wr_data), 32'(m_data));
            chk("locked", 32'(bus.locked), 32'(m_locked));
            if (m_locked) chk("owner", 32'(bus.owner), 32'(m_owner));
            chk("onehot", 32'($onehot0(bus.req_ready)), 32'd1);
            if (g >= 0) gq.push_back(g);
            chk("ready2", 32'(bus2.req_ready), rst ? 32'd0 : 32'(1 << m2_next));
            chk("onehot2", 32'($onehot0(bus2.req_ready)), 32'd1);
            if (!rst) g2q.push_back(m2_next);
        end
    end

    always @(negedge clk)
        assert ($onehot0(bus.req_ready) && $onehot0(bus2.req_ready))
            else $error("FAIL onehot assertion: %b %b", bus.req_ready, bus2.req_ready);

    // model update
    always @(posedge clk) begin
        int g;
        g = model_grant();
        if (rst) begin
            m_ptr <= 0; m_locked <= 1'b0; m_owner <= 0;
            m_wr_en <= 1'b0; m_addr <= '0; m_data <= '0; m2_next <= 0;
        end else begin
            m2_next <= 1 - m2_next;
            if (g >= 0) begin
                m_wr_en <= 1'b1;
                m_addr  <= bus.req_addr[g*AW +: AW];
                m_data  <= bus.req_data[g*DW +: DW];
                if (m_locked) begin
                    if (!bus.req_lock[g]) m_locked <= 1'b0;
                end else begin
                    m_ptr <= (g + 1) % N;
                    if (bus.req_lock[g]) begin
                        m_locked <= 1'b1;
                        m_owner  <= g;
                    end
                end
            end else begin
                m_wr_en <= 1'b0;
            end
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid  = '1;
        bus.req_lock   = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        for (int i = 0; i < N; i++) set_req(i, AW'(i), DW'(16'hA000 + i));
        bus2.req_valid = 2'b11;
        bus2.req_lock  = '0;
        bus2.req_addr  = '0;
        bus2.req_data  = '0;

        // reset with requests pending
        edge1();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        edge1();

        // single requester 2
        rst = 1'b0;
        bus.req_valid = 4'b0100;
        set_req(2, 3'd5, 16'hBEEF);
        @(negedge clk);
        chk("t1_ready", 32'(bus.req_ready), 32'b0100);
        edge1();
        bus.req_valid = '0;
        chk("t1_model_ptr", 32'(m_ptr), 32'd3);
        @(negedge clk);
        chk("t1_wr_en", 32'(bus.wr_en), 32'd1);
        chk("t1_wr_addr", 32'(bus.wr_addr), 32'd5);
        chk("t1_wr_data", 32'(bus.wr_data), 32'hBEEF);
        edge1();

        // all four valid after reset: round-robin
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        gq.delete();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_req(i, AW'(i), DW'(16'h2000 + c*16 + i));
            @(negedge clk);
            if (c >= 1) chk("t2_wr_en", 32'(bus.wr_en), 32'd1);
            edge1();
        end
        bus.req_valid = '0;
        chk("t2_len", 32'(gq.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("t2_seq", 32'(gq[i]), 32'(exp2[i]));

        // lock by requester 1 while 0 and 3 stay valid
        gq.delete();
        bus.req_valid = 4'b0001;
        edge1();
        bus.req_valid = 4'b1011;
        bus.req_lock  = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                chk("t3_locked", 32'(bus.locked), 32'd1);
                chk("t3_owner", 32'(bus.owner), 32'd1);
            end
            edge1();
        end
        bus.req_lock = 4'b0000;
        @(negedge clk);
        chk("t3_locked_last", 32'(bus.locked), 32'd1);
        chk("t3_ready_last", 32'(bus.req_ready), 32'b0010);
        edge1();
        @(negedge clk);
        chk("t3_released", 32'(bus.locked), 32'd0);
        chk("t3_ready3", 32'(bus.req_ready), 32'b1000);
        edge1();
        bus.req_valid = '0;
        chk("t3_len", 32'(gq.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk("t3_seq", 32'(gq[i]), 32'(exp3[i]));

        // owner 0 idles while requester 2 waits
        gq.delete();
        bus.req_valid = 4'b0101;
        bus.req_lock  = 4'b0001;
        edge1();
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_ready", 32'(bus.req_ready), 32'd0);
            chk("t4_locked", 32'(bus.locked), 32'd1);
            if (c >= 1) chk("t4_wr_en", 32'(bus.wr_en), 32'd0);
            edge1();
        end
        bus.req_valid = 4'b0101;
        bus.req_lock  = 4'b0000;
        @(negedge clk);
        chk("t4_owner_ready", 32'(bus.req_ready), 32'b0001);
        edge1();
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("t4_ready2", 32'(bus.req_ready), 32'b0100);
        edge1();
        bus.req_valid = '0;
        chk("t4_len", 32'(gq.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("t4_seq", 32'(gq[i]), 32'(exp4[i]));

        // reset while locked with the owner requesting
        bus.req_valid = 4'b0010;
        bus.req_lock  = 4'b0010;
        edge1();
        rst = 1'b1;
        bus.req_valid = 4'b1110;
        @(negedge clk);
        chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("t5_locked_before", 32'(bus.locked), 32'd1);
        edge1();
        rst = 1'b0;
        bus.req_lock = 4'b0000;
        @(negedge clk);
        chk("t5_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t5_locked", 32'(bus.locked), 32'd0);
        chk("t5_ready", 32'(bus.req_ready), 32'b0010);
        chk("t5_model_ptr", 32'(m_ptr), 32'd0);
        edge1();
        bus.req_valid = '0;
        edge1();
        edge1();

        // NREQ=2 instance alternation
        for (int i = 0; i < 4; i++) chk("t6_seq", 32'(g2q[i]), 32'(exp6[i]));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
